alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Next-generation processor ALU: parametrised datapath width, registered result and flags, valid/ready handshakes on both sides.
- Adds an iterative multiplier and a full flag set (zero, carry, negative, overflow, illegal).
- Sits between the register-file read stage and writeback in the micro-processor datapath; the control FSM issues one operation at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are 4 or more.
- MUL_EN, 1, 1 enables the MUL opcode; 0 makes MUL illegal and removes the multiplier.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; unsigned shift amount for shift and rotate ops.
- oper  in  4  opcode.
- out_valid  out  1  R and flags valid.
- out_ready  in  1  consumer accepts the result.
- R  out  WIDTH  result.
- zero  out  1  set when R equals 0.
- carry  out  1  carry, borrow or shifted-out bit (defined per op below).
- negative  out  1  equals R[WIDTH-1].
- overflow  out  1  signed overflow.
- illegal  out  1  opcode is undefined or disabled.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - While rst is high at a rising edge: state goes to IDLE, any multiply in progress is aborted, out_valid=0, R=0, and all flags are 0.
  - in_ready is 0 while rst is high.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL (logical), 6 SHR (logical), 7 ASR (arithmetic), 8 ROL (rotate left).
  - 9 MUL when MUL_EN=1.
  - All other opcodes, and 9 when MUL_EN=0: R=0, illegal=1, zero=1, all other flags 0.
- Handshake:
  - A request is accepted on a rising edge where in_valid and in_ready are both high.
  - A result is consumed on a rising edge where out_valid and out_ready are both high.
  - R and flags hold stable while out_valid=1 and out_ready=0.
- State machine, states IDLE, MUL, DONE:
  - IDLE: in_ready=1. Accepting a non-MUL op registers R and flags at that edge and goes to DONE (latency 1). Accepting MUL goes to MUL.
  - MUL: in_ready=0. One shift-add iteration per cycle. After exactly WIDTH iteration edges, R and flags are written and the state goes to DONE. out_valid therefore rises WIDTH+1 edges after the accept edge.
  - DONE: out_valid=1 and in_ready=out_ready. On consume with a simultaneous accept, the new op is processed as from IDLE (back-to-back throughput of 1 op/cycle for non-MUL ops). On consume with no accept, go to IDLE.
- Arithmetic rules (all unsigned WIDTH-bit, wrap-around):
  - ADD: carry = carry-out of bit WIDTH-1.
  - SUB: carry = borrow, i.e. 1 when A<B unsigned.
  - ADD/SUB overflow: standard two's-complement signed overflow.
  - AND/OR/XOR: carry=0, overflow=0.
- Shift and rotate rules (shift amount n = unsigned value of B):
  - SHL/SHR with n=0: R=A, carry=0.
  - SHL/SHR with 1<=n<=WIDTH: carry = last bit shifted out.
  - SHL/SHR with n>WIDTH: R=0, carry=0.
  - ASR: same rules, except vacated bits take A[WIDTH-1]; for n>=WIDTH, R is all A[WIDTH-1] bits and carry=A[WIDTH-1].
  - ROL: rotate by n mod WIDTH; carry=0.
  - Shift and rotate ops: overflow=0.
- MUL: unsigned product; R = low WIDTH bits; carry=1 when the high WIDTH bits are nonzero; overflow=0.
- Flags: zero and negative are derived from the final R for every op.
- Input sampling: inputs are sampled only at the accept edge. Operand or opcode changes during MUL have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum (OP_ADD..OP_MUL);
  - the flag struct {zero, carry, negative, overflow, illegal};
  - the state enum.
- One natural sub-module: alu_mul_iter, the WIDTH-cycle shift-add multiplier with start/done, instantiated only when MUL_EN=1.

Test Plan (all with WIDTH=8):
- ADD A=FF, B=01 -> R=00, zero=1, carry=1, overflow=0, negative=0; out_valid 1 edge after accept.
- SUB A=80, B=01 -> R=7F, overflow=1, carry=0, negative=0. SUB A=01, B=02 -> R=FF, carry=1, negative=1.
- Shifts:
  - ASR A=90, B=2 -> R=E4, carry=0.
  - SHL A=81, B=9 -> R=00, zero=1, carry=0.
  - SHR A=81, B=1 -> R=40, carry=1.
  - ROL A=81, B=9 -> R=03.
- MUL A=10, B=11 -> R=10, carry=1. in_ready=0 for 8 cycles; out_valid rises 9 edges after accept. Operands changed mid-op do not affect the result.
- Backpressure and illegal op:
  - Hold out_ready=0 for 3 cycles -> R and flags stable, in_ready=0.
  - Back-to-back ADDs with out_ready=1 -> one result per cycle.
  - oper=F -> R=0, illegal=1, zero=1.
- Reset mid-MUL: assert rst on the 4th MUL cycle -> next cycle IDLE, out_valid=0, all outputs 0, in_ready=1 after rst drops; no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the sequential ALU: opcodes, result flags
//                and control-FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Operation codes carried on the 4-bit oper field
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_ASR = 4'd7,
      OP_ROL = 4'd8,
      OP_MUL = 4'd9
   } opcode_t;

   // Flags registered alongside every result
   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
      logic overflow;
      logic illegal;
   } flags_t;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/result handshake bundle between the issuing stage
//                (master) and the sequential ALU (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       oper;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] R;
   logic             zero;
   logic             carry;
   logic             negative;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, A, B, oper, out_ready,
      input  in_ready, out_valid, R, zero, carry, negative, overflow, illegal
   );

   modport slave (
      input  in_valid, A, B, oper, out_ready,
      output in_ready, out_valid, R, zero, carry, negative, overflow, illegal
   );
endinterface : alu_seq_if
`default_nettype wire

// File: rtl/alu_seq_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_iter
//  Description : WIDTH-cycle shift-add unsigned multiplier. Operands load on
//                i_start; o_done/o_prod present the finished product during
//                the cycle of the last iteration so the caller can register it
//                on that same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 i_start,
   input  wire logic [WIDTH-1:0]     i_a,
   input  wire logic [WIDTH-1:0]     i_b,
   output logic                      o_done,
   output logic [2*WIDTH-1:0]        o_prod
);
   localparam int c_CNT_W = $clog2(WIDTH + 1);

   logic                 r_busy;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_p;      // {partial high half, remaining multiplier bits}

   logic [WIDTH:0]       w_addend;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_p_next;

   // One iteration: add multiplicand into the high half when the LSB is set, then shift right
   always_comb begin
      w_addend = r_p[0] ? {1'b0, r_mcand} : '0;
      w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + w_addend;
      w_p_next = {w_sum, r_p[WIDTH-1:1]};
   end

   assign o_done = r_busy && (r_cnt == c_CNT_W'(1));
   assign o_prod = w_p_next;

   // Iteration state: load on start, step once per cycle while busy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_mcand <= '0;
         r_p     <= '0;
      end else if (i_start) begin
         r_busy  <= 1'b1;
         r_cnt   <= c_CNT_W'(WIDTH);
         r_mcand <= i_a;
         r_p     <= {{WIDTH{1'b0}}, i_b};
      end else if (r_busy) begin
         r_p   <= w_p_next;
         r_cnt <= r_cnt - c_CNT_W'(1);
         if (r_cnt == c_CNT_W'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end
endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU with registered result/flags, valid/ready
//                handshakes on both sides and an optional iterative multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input wire logic    clk,
   input wire logic    rst,
   alu_seq_if.slave    bus
);
   // Rotate amount is B mod WIDTH; WIDTH always fits in WIDTH bits for WIDTH >= 4
   localparam logic [WIDTH-1:0] c_WIDTH_V = WIDTH'(WIDTH);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_R;
   flags_t               r_flags;

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_consume;
   logic                 w_is_mul;
   logic                 w_mul_start;
   logic                 w_load_alu;
   logic                 w_load_mul;
   logic                 w_mul_done;
   logic [2*WIDTH-1:0]   w_mul_prod;

   logic [WIDTH:0]         w_add;
   logic [WIDTH:0]         w_sub;
   logic [WIDTH:0]         w_shl_ext;   // {carry, R}
   logic [WIDTH:0]         w_shr_ext;   // {R, carry}
   logic signed [WIDTH:0]  w_asr_ext;   // {R, carry}
   logic [WIDTH-1:0]       w_rot_amt;
   logic [2*WIDTH-1:0]     w_rol_ext;

   logic [WIDTH-1:0]     w_alu_R;
   logic                 w_alu_c;
   logic                 w_alu_ov;
   logic                 w_alu_ill;
   flags_t               w_alu_flags;
   flags_t               w_mul_flags;

   // Shifts are done on a one-bit-extended word so the last bit shifted out
   // lands in the extension bit; oversized amounts naturally yield 0 (or sign fill for ASR).
   assign w_add     = {1'b0, bus.A} + {1'b0, bus.B};
   assign w_sub     = {1'b0, bus.A} - {1'b0, bus.B};
   assign w_shl_ext = {1'b0, bus.A} << bus.B;
   assign w_shr_ext = {bus.A, 1'b0} >> bus.B;
   assign w_asr_ext = $signed({bus.A, 1'b0}) >>> bus.B;
   assign w_rot_amt = bus.B % c_WIDTH_V;
   assign w_rol_ext = {bus.A, bus.A} << w_rot_amt;

   // Single-cycle result and flags for every non-MUL opcode
   always_comb begin
      w_alu_R   = '0;
      w_alu_c   = 1'b0;
      w_alu_ov  = 1'b0;
      w_alu_ill = 1'b0;
      case (opcode_t'(bus.oper))
         OP_ADD: begin
            w_alu_R  = w_add[WIDTH-1:0];
            w_alu_c  = w_add[WIDTH];
            w_alu_ov = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                       (w_add[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_R  = w_sub[WIDTH-1:0];
            w_alu_c  = w_sub[WIDTH];
            w_alu_ov = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                       (w_sub[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND: w_alu_R = bus.A & bus.B;
         OP_OR:  w_alu_R = bus.A | bus.B;
         OP_XOR: w_alu_R = bus.A ^ bus.B;
         OP_SHL: begin
            w_alu_R = w_shl_ext[WIDTH-1:0];
            w_alu_c = w_shl_ext[WIDTH];
         end
         OP_SHR: begin
            w_alu_R = w_shr_ext[WIDTH:1];
            w_alu_c = w_shr_ext[0];
         end
         OP_ASR: begin
            w_alu_R = w_asr_ext[WIDTH:1];
            w_alu_c = w_asr_ext[0];
         end
         OP_ROL: w_alu_R = w_rol_ext[2*WIDTH-1:WIDTH];
         OP_MUL: w_alu_ill = !MUL_EN;
         default: w_alu_ill = 1'b1;
      endcase
      w_alu_flags.zero     = (w_alu_R == '0);
      w_alu_flags.carry    = w_alu_c;
      w_alu_flags.negative = w_alu_R[WIDTH-1];
      w_alu_flags.overflow = w_alu_ov;
      w_alu_flags.illegal  = w_alu_ill;
   end

   // Flags for the multiplier's final product
   always_comb begin
      w_mul_flags.zero     = (w_mul_prod[WIDTH-1:0] == '0);
      w_mul_flags.carry    = |w_mul_prod[2*WIDTH-1:WIDTH];
      w_mul_flags.negative = w_mul_prod[WIDTH-1];
      w_mul_flags.overflow = 1'b0;
      w_mul_flags.illegal  = 1'b0;
   end

   // In DONE a new request may be taken only on the cycle the result is consumed
   assign w_in_ready = !rst && ((r_state == ST_IDLE) ||
                                ((r_state == ST_DONE) && bus.out_ready));
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_consume  = (r_state == ST_DONE) && bus.out_ready;
   assign w_is_mul   = MUL_EN && (bus.oper == OP_MUL);

   // Next-state: an accept (possible in IDLE or on a consuming DONE cycle) overrides the default
   always_comb begin
      w_state_nxt = r_state;
      w_load_alu  = 1'b0;
      w_load_mul  = 1'b0;
      w_mul_start = 1'b0;
      case (r_state)
         ST_IDLE: w_state_nxt = ST_IDLE;
         ST_MUL: begin
            if (w_mul_done) begin
               w_load_mul  = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = w_consume ? ST_IDLE : ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_accept) begin
         if (w_is_mul) begin
            w_mul_start = 1'b1;
            w_state_nxt = ST_MUL;
         end else begin
            w_load_alu  = 1'b1;
            w_state_nxt = ST_DONE;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result/flag registers; held while waiting for the consumer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_R     <= '0;
         r_flags <= '0;
      end else if (w_load_alu) begin
         r_R     <= w_alu_R;
         r_flags <= w_alu_flags;
      end else if (w_load_mul) begin
         r_R     <= w_mul_prod[WIDTH-1:0];
         r_flags <= w_mul_flags;
      end
   end

   generate
      if (MUL_EN) begin : g_mul
         alu_mul_iter #(
            .WIDTH (WIDTH)
         ) u_mul (
            .clk     (clk),
            .rst     (rst),
            .i_start (w_mul_start),
            .i_a     (bus.A),
            .i_b     (bus.B),
            .o_done  (w_mul_done),
            .o_prod  (w_mul_prod)
         );
      end else begin : g_no_mul
         assign w_mul_done = 1'b0;
         assign w_mul_prod = '0;
      end
   endgenerate

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.R         = r_R;
   assign bus.zero      = r_flags.zero;
   assign bus.carry     = r_flags.carry;
   assign bus.negative  = r_flags.negative;
   assign bus.overflow  = r_flags.overflow;
   assign bus.illegal   = r_flags.illegal;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH=8, MUL_EN=1) against a
//                behavioural integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(
      .WIDTH  (W),
      .MUL_EN (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Flag order in comparisons: {zero, carry, negative, overflow, illegal}
   logic [4:0] w_fl;
   assign w_fl = {bus.zero, bus.carry, bus.negative, bus.overflow, bus.illegal};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   // Behavioural model computed with plain integer arithmetic
   function automatic void ref_alu(input int a, input int b, input int op,
                                   output int r, output logic [4:0] fl);
      int c, ov, ill, s, sa, k;
      r = 0; c = 0; ov = 0; ill = 0;
      sa = to_signed(a);
      case (op)
         0: begin
            s  = a + b; r = s % 256; c = (s > 255);
            s  = sa + to_signed(b); ov = (s > 127 || s < -128);
         end
         1: begin
            r  = (a - b + 256) % 256; c = (a < b);
            s  = sa - to_signed(b); ov = (s > 127 || s < -128);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: if (b == 0) r = a;
            else if (b <= W) begin r = (a << b) & 255; c = (a >> (W - b)) & 1; end
         6: if (b == 0) r = a;
            else if (b <= W) begin r = a >> b; c = (a >> (b - 1)) & 1; end
         7: if (b == 0) r = a;
            else if (b < W) begin r = (sa >>> b) & 255; c = (sa >>> (b - 1)) & 1; end
            else begin r = (a >= 128) ? 255 : 0; c = (a >= 128); end
         8: begin k = b % W; r = ((a << k) | (a >> (W - k))) & 255; end
         9: begin s = a * b; r = s & 255; c = (s > 255); end
         default: ill = 1;
      endcase
      fl = {r == 0, c[0], r >= 128, ov[0], ill[0]};
   endfunction

   // Issue one op, check latency / ready during MUL / result / drain
   task automatic run_op(input int a, input int b, input int op, input string tag);
      int r, lat, exp_lat, t;
      logic [4:0] fl;
      bit leak;
      ref_alu(a, b, op, r, fl);
      exp_lat = (op == 9) ? W + 1 : 1;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = a[W-1:0]; bus.B = b[W-1:0]; bus.oper = op[3:0];
      t = 0;
      while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
      if (!bus.in_ready) check_eq({tag, "_acc_timeout"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.A = W'($urandom); bus.B = W'($urandom); bus.oper = 4'($urandom);
      lat = 1; leak = 1'b0;
      while (!bus.out_valid && lat < 40) begin
         if (bus.in_ready) leak = 1'b1;
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      if (op == 9) check_eq({tag, "_rdy_busy"}, 64'(leak), 64'd0);
      check_eq({tag, "_R"}, 64'(bus.R), 64'(r));
      check_eq({tag, "_flags"}, 64'(w_fl), 64'(fl));
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int r0;
      logic [4:0] f0;
      int exp_r[$];
      logic [4:0] exp_f[$];
      bit stale;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.A = '0; bus.B = '0; bus.oper = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_R", 64'(bus.R), 64'd0);
      check_eq("rst_flags", 64'(w_fl), 64'd0);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_in_ready", 64'(bus.in_ready), 64'd1);

      // Directed cases, including shift/rotate boundaries
      run_op(8'hFF, 8'h01, 0, "add_ff_01");
      run_op(8'h80, 8'h01, 1, "sub_80_01");
      run_op(8'h01, 8'h02, 1, "sub_01_02");
      run_op(8'h55, 8'h55, 1, "sub_eq");
      run_op(8'h7F, 8'h01, 0, "add_ovf");
      run_op(8'h90, 2, 7, "asr_90_2");
      run_op(8'h81, 9, 5, "shl_81_9");
      run_op(8'h81, 8, 5, "shl_81_8");
      run_op(8'h81, 1, 6, "shr_81_1");
      run_op(8'h81, 8, 6, "shr_81_8");
      run_op(8'h81, 0, 6, "shr_81_0");
      run_op(8'h90, 8, 7, "asr_90_8");
      run_op(8'h90, 200, 7, "asr_90_200");
      run_op(8'h81, 9, 8, "rol_81_9");
      run_op(8'h10, 8'h11, 9, "mul_10_11");
      run_op(8'hFF, 8'hFF, 9, "mul_ff_ff");
      run_op(8'h12, 8'h34, 15, "ill_f");
      run_op(8'h12, 8'h34, 10, "ill_a");

      // Backpressure: result held, in_ready low while out_ready=0
      ref_alu(8'h3C, 8'h0F, 4, r0, f0);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.A = 8'h3C; bus.B = 8'h0F; bus.oper = 4'd4;
      @(posedge clk); @(negedge clk);
      bus.A = 8'hAA; bus.B = 8'h00; bus.oper = 4'd0;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_valid", 64'(bus.out_valid), 64'd1);
         check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check_eq("bp_R", 64'(bus.R), 64'(r0));
         check_eq("bp_flags", 64'(w_fl), 64'(f0));
         @(posedge clk); @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq("bp_drain", 64'(bus.out_valid), 64'd0);

      // Back-to-back ADDs with out_ready=1: one result per cycle
      bus.out_ready = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            int a, b, r;
            logic [4:0] f;
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            ref_alu(a, b, 0, r, f);
            exp_r.push_back(r); exp_f.push_back(f);
            bus.in_valid = 1'b1; bus.A = a[W-1:0]; bus.B = b[W-1:0]; bus.oper = 4'd0;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (i > 0) begin
            check_eq("b2b_valid", 64'(bus.out_valid), 64'd1);
            check_eq("b2b_R", 64'(bus.R), 64'(exp_r.pop_front()));
            check_eq("b2b_flags", 64'(w_fl), 64'(exp_f.pop_front()));
         end
         @(posedge clk); @(negedge clk);
      end
      bus.out_ready = 1'b0;
      check_eq("b2b_drain", 64'(bus.out_valid), 64'd0);

      // Reset on the 4th MUL cycle aborts the multiply
      bus.in_valid = 1'b1; bus.A = 8'h0F; bus.B = 8'h0F; bus.oper = 4'd9;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check_eq("rmul_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rmul_R", 64'(bus.R), 64'd0);
      check_eq("rmul_flags", 64'(w_fl), 64'd0);
      check_eq("rmul_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check_eq("rmul_ready_after", 64'(bus.in_ready), 64'd1);
      stale = 1'b0;
      repeat (12) begin
         if (bus.out_valid || bus.R != '0) stale = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      check_eq("rmul_no_stale", 64'(stale), 64'd0);

      // Randomized ops against the model
      for (int i = 0; i < 150; i++) begin
         int a, b, op;
         a  = $urandom_range(0, 255);
         b  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
         op = $urandom_range(0, 15);
         run_op(a, b, op, $sformatf("rnd%0d_op%0d", i, op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule : tb_alu_seq
`default_nettype wire
